dmem_rr_arbiter: RTL
====================

Name: dmem_rr_arbiter

Overview:
- Shares the single-port synchronous data memory between the processor's four cores using a round-robin grant.
- Sits between the per-core load/store ports and the data BRAM inside `processor`.
- Handles one transaction at a time; reads return through a registered data bus.
- Cores that have raised `end_op` are masked out of arbitration.

Parameters:
- NUM_CORES, 4, number of requesting cores. Fixed at 4 for this revision.
- ADDR_W, 12, data memory address width.
- DATA_W, 8, data word width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_CORES  per-core request; held until `gnt`.
- we  in  NUM_CORES  per-core write flag; 1 = write, 0 = read.
- addr  in  NUM_CORES*ADDR_W  per-core address, flattened; core k occupies bits [k*ADDR_W +: ADDR_W].
- wdata  in  NUM_CORES*DATA_W  per-core write data, flattened the same way.
- end_op  in  NUM_CORES  core finished; its `req` is ignored.
- gnt  out  NUM_CORES  one-hot, 1-cycle pulse: transaction accepted.
- rvalid  out  NUM_CORES  one-hot, 1-cycle pulse: `rdata` valid for that core.
- rdata  out  DATA_W  registered read data, shared by all cores.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read enable.
- stat_gnt_cnt  out  NUM_CORES*16  per-core grant counters (optional feature).

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=0, owner=0.
  - gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata all 0.
  - A transaction in flight is abandoned: no `gnt`/`rvalid` is issued for it, and `mem_en` drops immediately.
- Eligible set: elig = req & ~end_op.
- State IDLE:
  - If elig≠0, pick the winner as the first set bit of elig searching from rr_ptr upward, mod 4.
  - Register owner, command and operands, then go to ISSUE.
  - Otherwise stay in IDLE.
- State ISSUE (exactly 1 cycle):
  - mem_en=1, mem_we=we[owner], mem_addr/mem_wdata = owner's operands (registered).
  - gnt[owner]=1.
  - rr_ptr <= owner+1 mod 4.
  - Next state: write → IDLE; read → RDATA.
- State RDATA (1 cycle):
  - mem_en=0.
  - On the exiting edge: rdata <= mem_rdata and rvalid[owner] <= 1.
  - Next state: IDLE.
  - rvalid is therefore high during the following IDLE cycle only.
- rdata holds its value until the next read completes.
- Latency:
  - Write: req sampled at edge E0 → gnt and memory write during cycle E0–E1.
  - Read: rvalid during cycle E2–E3.
  - Best-case throughput: one write per 2 cycles, one read per 3 cycles.
- Handshake:
  - The core holds req/we/addr/wdata stable until it sees gnt.
  - The core drops req in the cycle following gnt unless it issues a new request.
  - Operands are captured at the IDLE→ISSUE edge; later changes have no effect.
- Boundary conditions:
  - All four cores requesting: grants go in the order rr_ptr, rr_ptr+1, … — no starvation; each core waits at most 3 transactions.
  - Only one eligible core: it is granted repeatedly.
  - end_op rising while a core's req is pending (not yet granted): the request is dropped with no gnt.
  - end_op rising after gnt: the transaction completes normally, including rvalid.
  - req deasserted before grant: withdrawn, no side effects.
  - rr_ptr wraps from 3 to 0.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - stat_gnt_cnt[k] increments by 1 on every gnt[k].
  - Counters saturate at 16'hFFFF.
  - Counters reset to 0 by rst.
- Undefined:
  - No counter logic is generated.
  - stat_gnt_cnt is tied to 0; the port is kept for a stable interface.

Decomposition:
- Package dmem_arb_pkg holds:
  - state encoding: IDLE=2'd0, ISSUE=2'd1, RDATA=2'd2.
  - NUM_CORES=4 and CORE_ID_W=2.
  - the stats counter width (16).
- Sub-module rr_picker (combinational): inputs elig[3:0] and ptr[1:0]; outputs found and winner[1:0]. Reused by future shared-resource arbiters.

Test Plan:
- Reset mid-read: assert rst while in RDATA → rvalid stays 0, all outputs 0, next grant starts from core 0.
- Single write: core 2 writes addr 12'h010, data 8'hA5 → gnt[2] one cycle after req; mem_we=1, mem_addr=12'h010, mem_wdata=8'hA5 in the same cycle; back in IDLE the next cycle.
- Read-back: core 1 reads 12'h010 → rdata=8'hA5 with rvalid=4'b0010 two cycles after gnt[1].
- Fairness: req=4'b1111 held, with each core re-requesting after its gnt → grant order 0,1,2,3,0,… over 8 grants; with the stats feature enabled, each stat_gnt_cnt = 2.
- Masking: end_op=4'b0101, req=4'b1111 → only cores 1 and 3 are granted, alternating; cores 0 and 2 never receive gnt.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory round-robin arbiter: FSM encoding,
// core count, and helpers used by the arbiter and its grant counters.
package dmem_arb_pkg;

    localparam int NUM_CORES = 4;
    localparam int CORE_ID_W = 2;
    localparam int STAT_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } arb_state_t;

    function automatic logic [NUM_CORES-1:0] core_onehot(input logic [CORE_ID_W-1:0] id);
        return NUM_CORES'(1) << id;
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/dmem_rr_arbiter_if.sv
// Core-side load/store ports and memory-side port of the data-memory arbiter.
// slave is the arbiter's view; master is the cores/memory view.
interface dmem_rr_arbiter_if
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    import dmem_arb_pkg::*;

    logic [NUM_CORES-1:0]        req;
    logic [NUM_CORES-1:0]        we;
    logic [NUM_CORES*ADDR_W-1:0] addr;
    logic [NUM_CORES*DATA_W-1:0] wdata;
    logic [NUM_CORES-1:0]        end_op;
    logic [NUM_CORES-1:0]        gnt;
    logic [NUM_CORES-1:0]        rvalid;
    logic [DATA_W-1:0]           rdata;
    logic                        mem_en;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [DATA_W-1:0]           mem_rdata;
    logic [NUM_CORES*STAT_W-1:0] stat_gnt_cnt;

    modport slave (
        input  req, we, addr, wdata, end_op, mem_rdata,
        output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, stat_gnt_cnt
    );

    modport master (
        output req, we, addr, wdata, end_op, mem_rdata,
        input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, stat_gnt_cnt
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of elig searching upward
// from ptr, wrapping modulo NUM_CORES.
module rr_picker
    import dmem_arb_pkg::*;
(
    input  logic [NUM_CORES-1:0] elig,
    input  logic [CORE_ID_W-1:0] ptr,
    output logic                 found,
    output logic [CORE_ID_W-1:0] winner
);

    logic [CORE_ID_W-1:0] idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            idx = ptr + CORE_ID_W'(i);
            if (!found && elig[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between four cores.
// Define DMEM_ARB_STATS_EN to build the per-core saturating grant counters.
module dmem_rr_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    dmem_rr_arbiter_if.slave bus
);

    arb_state_t           state, state_nxt;
    logic [CORE_ID_W-1:0] rr_ptr;
    logic [CORE_ID_W-1:0] owner;
    logic                 cmd_we;
    logic [ADDR_W-1:0]    cmd_addr;
    logic [DATA_W-1:0]    cmd_wdata;
    logic [NUM_CORES-1:0] rvalid;
    logic [DATA_W-1:0]    rdata;

    logic [NUM_CORES-1:0] elig;
    logic                 found;
    logic [CORE_ID_W-1:0] winner;
    logic                 capture;
    logic [NUM_CORES-1:0] gnt;
    logic                 mem_en;
    logic                 mem_we;

    // Finished cores drop out of arbitration even with req still high.
    assign elig = bus.req & ~bus.end_op;

    rr_picker u_picker (
        .elig   (elig),
        .ptr    (rr_ptr),
        .found  (found),
        .winner (winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        gnt       = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    capture   = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                gnt       = core_onehot(owner);
                mem_en    = 1'b1;
                mem_we    = cmd_we;
                state_nxt = cmd_we ? IDLE : RDATA;
            end
            RDATA:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are frozen at the IDLE->ISSUE edge; read data lands on RDATA exit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            owner     <= '0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            rvalid    <= '0;
            rdata     <= '0;
        end else begin
            rvalid <= '0;
            if (capture) begin
                owner     <= winner;
                cmd_we    <= bus.we[winner];
                cmd_addr  <= bus.addr[winner*ADDR_W +: ADDR_W];
                cmd_wdata <= bus.wdata[winner*DATA_W +: DATA_W];
            end
            if (state == ISSUE) begin
                rr_ptr <= owner + CORE_ID_W'(1);
            end
            if (state == RDATA) begin
                rdata  <= bus.mem_rdata;
                rvalid <= core_onehot(owner);
            end
        end
    end

    assign bus.gnt       = gnt;
    assign bus.rvalid    = rvalid;
    assign bus.rdata     = rdata;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = cmd_addr;
    assign bus.mem_wdata = cmd_wdata;

`ifdef DMEM_ARB_STATS_EN
    for (genvar k = 0; k < NUM_CORES; k++) begin : g_stat
        logic [STAT_W-1:0] cnt;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (gnt[k]) begin
                cnt <= sat_inc(cnt);
            end
        end
        assign bus.stat_gnt_cnt[k*STAT_W +: STAT_W] = cnt;
    end
`else
    assign bus.stat_gnt_cnt = '0;
`endif

endmodule
